// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and the
// IF/ID pipeline register, with stall, redirect (flush) and bubble insertion.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        if_id_illegal,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ACT_NORMAL,
    ACT_STALL,
    ACT_REDIRECT
  } action_e;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  action_e     action;

  logic [31:0] pc_d,        pc_q;
  logic [31:0] inst_d,      inst_q;
  logic [31:0] id_pc_d,     id_pc_q;
  logic [31:0] id_pc4_d,    id_pc4_q;
  logic        valid_d,     valid_q;
  logic        illegal_d,   illegal_q;
  logic [31:0] count_d,     count_q;

  // Redirect outranks stall so a resolved branch is never lost behind a hazard.
  always_comb begin
    if (redirect) begin
      action = ACT_REDIRECT;
    end else if (stall) begin
      action = ACT_STALL;
    end else begin
      action = ACT_NORMAL;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    id_pc_d   = id_pc_q;
    id_pc4_d  = id_pc4_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    count_d   = count_q;

    unique case (action)
      ACT_REDIRECT: begin
        // Flush: the word at the old PC is discarded; decode PC fields hold.
        pc_d      = {redirect_target[31:2], 2'b00};
        inst_d    = NOP_INST;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
      end
      ACT_STALL: begin
      end
      ACT_NORMAL: begin
        inst_d    = instr_rdata;
        id_pc_d   = pc_q;
        id_pc4_d  = pc_q + 32'd4;
        valid_d   = 1'b1;
        illegal_d = (instr_rdata[1:0] != 2'b11);
        pc_d      = pc_q + 32'd4;
        count_d   = count_q + 32'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC_ALIGNED;
      inst_q    <= NOP_INST;
      id_pc_q   <= '0;
      id_pc4_q  <= 32'd4;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      id_pc_q   <= id_pc_d;
      id_pc4_q  <= id_pc4_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign instr_addr     = pc_q;
  assign if_id_inst     = inst_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign if_id_valid    = valid_q;
  assign if_id_illegal  = illegal_q;
  assign fetch_count    = count_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with the IF/ID pipeline register.
- Holds the program counter and drives the instruction-memory address.
- Captures the returned instruction word and presents it, with its PC, to the decode stage. Decode contains the immediate generator, which consumes if_id_inst as its inst_code input.
- Handles pipeline stall, control-flow redirect (flush) and bubble insertion.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (ADDI x0,x0,0) placed in IF/ID on reset or flush.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: freeze PC and IF/ID.
- redirect  input  1  taken branch/JAL/JALR resolved downstream: flush and load redirect_target.
- redirect_target  input  32  new PC; bits [1:0] ignored (forced to 0).
- instr_addr  output  32  instruction-memory byte address; combinational copy of PC.
- instr_rdata  input  32  instruction word from memory, combinational read of instr_addr.
- if_id_inst  output  32  registered instruction to decode.
- if_id_pc  output  32  PC of if_id_inst.
- if_id_pc_plus4  output  32  if_id_pc + 4, registered.
- if_id_valid  output  1  1 = if_id_inst is a real fetched instruction; 0 = bubble.
- if_id_illegal  output  1  registered: instr_rdata[1:0] != 2'b11 at capture (non-32-bit encoding).
- fetch_count  output  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset (async assert, any time including mid-stall or mid-redirect). Outputs take these values immediately, without waiting for clk:
  - pc = RESET_PC, so instr_addr = RESET_PC.
  - if_id_inst = NOP_INST, if_id_pc = 0, if_id_pc_plus4 = 4.
  - if_id_valid = 0, if_id_illegal = 0, fetch_count = 0.
- Reset release: the first rising edge with reset low performs a normal fetch of RESET_PC.
- Priority on each rising edge: reset > redirect > stall > normal.
- redirect = 1, regardless of stall:
  - pc <= {redirect_target[31:2], 2'b00}.
  - if_id_inst <= NOP_INST, if_id_valid <= 0, if_id_illegal <= 0.
  - if_id_pc and if_id_pc_plus4 hold; fetch_count holds.
  - The instruction currently at instr_addr is discarded.
- stall = 1, redirect = 0: pc, all if_id_* outputs and fetch_count hold. instr_addr stays stable.
- Normal (stall = 0, redirect = 0):
  - if_id_inst <= instr_rdata, if_id_pc <= pc, if_id_pc_plus4 <= pc + 4.
  - if_id_valid <= 1, if_id_illegal <= (instr_rdata[1:0] != 2'b11).
  - pc <= pc + 4.
  - fetch_count <= fetch_count + 1.
- Latency:
  - Instruction at address A appears on if_id_inst one cycle after instr_addr = A with no stall or redirect.
  - Redirect-to-first-valid-decode is 2 edges: edge 1 loads PC and inserts a bubble; edge 2 captures the target instruction.
- Arithmetic:
  - All PC arithmetic is modulo 2^32: pc = 32'hFFFF_FFFC advances to 32'h0000_0000.
  - if_id_pc_plus4 wraps the same way.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
- PC bits [1:0] are always 0.
- instr_rdata is sampled only on normal-advance edges; its value during stall, redirect or reset cycles has no effect.
- Illegal flag:
  - Informational only. The instruction is still forwarded with if_id_valid = 1.
  - Decode or trap logic consumes the flag.

Test Plan:
- Reset then 4 free-running cycles, memory returns 32'h00A00093, 32'h00108113, 32'h002181B3, 32'hFFC00213:
  - if_id_pc = 0, 4, 8, 12 with matching inst, valid = 1.
  - fetch_count = 4; instr_addr = 16.
- Stall held 3 cycles after the 2nd fetch: if_id_pc stays 4, instr_addr stays 8, fetch_count stays 2. On release, next capture is pc 8.
- Redirect to 32'h0000_0103 at pc 12:
  - Next edge: instr_addr = 32'h100, if_id_inst = 32'h00000013, valid = 0.
  - Following edge: if_id_pc = 32'h100, valid = 1.
- Redirect and stall asserted together: redirect wins, PC loads target, bubble inserted, fetch_count unchanged.
- Redirect to 32'hFFFF_FFFC, then 2 normal edges:
  - if_id_pc = 32'hFFFF_FFFC, if_id_pc_plus4 = 0.
  - Next capture if_id_pc = 0.
- Memory returns 32'h0000_4501 (compressed encoding): if_id_illegal = 1, valid = 1. Next word 32'h00000013: illegal = 0.
- Reset asserted asynchronously mid-stall (between clock edges): outputs go to reset values immediately, before the next clk edge.
